// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  // Codes the game core treats as submit keys.
  localparam logic [3:0] KEY_SUBMIT_LETTER = 4'd9;   // R3C0
  localparam logic [3:0] KEY_SUBMIT_WORD   = 4'd11;  // R3C2

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Bit position of the set bit in a one-hot vector (0 when nothing is set).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_ROWS-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (v[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, on terminal count.
module scan_tick_gen #(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero after the terminal count.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: one-hot column drive, row sampling once per
// column dwell, press/release debounce, one key_valid strobe per press.
// Optional build macro KEYPAD_AUTO_REPEAT_EN: re-strobes key_valid every
// REPEAT_SAMPLES ticks while a key stays held.
// DEBOUNCE_SAMPLES is expected to be at least 2.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV         = 1000,
  parameter int DEBOUNCE_SAMPLES = 8,
  parameter int REPEAT_SAMPLES   = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_held,
  output logic                multi_press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic tick;

  state_e              state_q, state_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_ROWS-1:0] pat_q, pat_d;
  logic [3:0]          pend_code_q, pend_code_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic                multi_q, multi_d;

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SAMPLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat_samples;
  assign unused_repeat_samples = ^REPEAT_SAMPLES;
`endif

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic                row_zero, row_multi;
  logic [1:0]          row_r, col_c;
  logic [3:0]          row_code;
  logic [NUM_COLS-1:0] col_next;
  logic [CNT_W-1:0]    cnt_inc;

  // Row decode for the current sample and the code it would produce.
  always_comb begin
    row_zero  = (row == '0);
    row_multi = ((row & (row - 4'd1)) != '0);
    // row[3] is R0, so the row number counts down from the top bit.
    row_r     = 2'(NUM_ROWS - 1) - onehot_to_idx(row);
    col_c     = onehot_to_idx({1'b0, col_q});
    row_code  = ({2'b00, row_r} * 4'd3) + {2'b00, col_c};
    col_next  = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and registered-output logic; everything advances only on a tick.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch; combinational blocks use '='.
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    pend_code_d = pend_code_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    key_valid_d = 1'b0;
    multi_d     = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_zero) begin
            col_d = col_next;
          end else if (row_multi) begin
            multi_d = 1'b1;
            col_d   = col_next;
          end else begin
            pat_d       = row;
            pend_code_d = row_code;
            cnt_d       = CNT_W'(1);
            state_d     = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_LAST) begin
              key_valid_d = 1'b1;
              key_code_d  = pend_code_q;
              key_held_d  = 1'b1;
              state_d     = HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
              rep_d       = '0;
`endif
            end
          end else begin
            // Bounce: resume scanning from the column we are parked on.
            state_d = SCAN;
          end
        end
        HELD: begin
          if (row_zero) begin
            cnt_d   = CNT_W'(1);
            state_d = RELEASE;
          end
`ifdef KEYPAD_AUTO_REPEAT_EN
          else if (rep_q == REP_LAST) begin
            rep_d       = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
`endif
        end
        RELEASE: begin
          if (row_zero) begin
            cnt_d = cnt_inc;
            if (cnt_q == CNT_LAST) begin
              key_held_d = 1'b0;
              col_d      = col_next;
              state_d    = SCAN;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses '<=' so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= 3'b001;
      cnt_q       <= '0;
      pat_q       <= '0;
      pend_code_q <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      pend_code_q <= pend_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_q     <= multi_d;
`ifdef KEYPAD_AUTO_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col         = col_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_held    = key_held_q;
  assign multi_press = multi_q;

endmodule
